// File: rtl/udp_pkg.sv
// Shared definitions for the UDP receive path: FSM states, header sizes
// and the protocol constants matched against incoming frames.
package udp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    ETH_HDR,
    IP_HDR,
    UDP_HDR,
    PAYLOAD,
    DROP
  } rx_state_t;

  localparam logic [15:0] ETH_HDR_LEN    = 16'd14;
  localparam logic [15:0] IP_HDR_LEN     = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN    = 16'd8;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam logic [15:0] MIN_PREAMBLE   = 16'd6;
  localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/udp_rx_word_pack.sv
// Packs payload bytes big-endian into 32-bit words; a short final word
// carries a left-aligned keep mask with the unused lanes zeroed.
module udp_rx_word_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  input  logic        byte_last,
  output logic [31:0] word,
  output logic        word_vld,
  output logic [3:0]  word_keep,
  output logic        word_last
);

  logic [31:0] acc_p0;
  logic [1:0]  idx_p0;
  logic [31:0] merged;

  assign merged = acc_p0 | ({byte_in, 24'h000000} >> {idx_p0, 3'b000});

  // p0 -> p1: word completes on the 4th byte or on the frame's last byte
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_p0    <= '0;
      idx_p0    <= '0;
      word      <= '0;
      word_vld  <= 1'b0;
      word_keep <= '0;
      word_last <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      if (clr) begin
        acc_p0 <= '0;
        idx_p0 <= '0;
      end else if (byte_vld) begin
        if (byte_last || idx_p0 == 2'd3) begin
          word      <= merged;
          word_vld  <= 1'b1;
          word_keep <= ~(4'b0111 >> idx_p0);
          word_last <= byte_last;
          acc_p0    <= '0;
          idx_p0    <= '0;
        end else begin
          acc_p0 <= merged;
          idx_p0 <= idx_p0 + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/udp_rx_unpack.sv
// GMII receiver that filters Ethernet/IPv4/UDP headers for this station
// and delivers the UDP payload as 32-bit words with keep/last.
module udp_rx_unpack
  import udp_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC  = 48'h00_0A_35_01_FE_C0,
  parameter logic [31:0] LOCAL_IP   = 32'hC0_A8_00_02,
  parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
  input  logic        e_rxc,
  input  logic        reset,
  input  logic        e_rxdv,
  input  logic        e_rxer,
  input  logic [7:0]  e_rxd,
  output logic [31:0] rx_data,
  output logic        rx_data_valid,
  output logic [3:0]  rx_data_keep,
  output logic        rx_data_last,
  output logic [15:0] rx_total_length,
  output logic [15:0] rx_data_length,
  output logic        data_received,
  output logic        rx_frame_err
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  rx_state_t   state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] total_len_nxt, data_len_nxt;
  logic        done_nxt, err_nxt;
  logic        pk_vld, pk_last, pk_clr;
  logic        abort;
  logic        rxdv_p1;
  logic [47:0] hdr_p1;

  // Only a rising e_rxdv may start a frame, so a reset mid-frame drops the remainder.
  assign abort = (state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD}) && (!e_rxdv || e_rxer);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    total_len_nxt = rx_total_length;
    data_len_nxt  = rx_data_length;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    pk_vld        = 1'b0;
    pk_last       = 1'b0;
    pk_clr        = (state != PAYLOAD);
    if (abort) begin
      err_nxt   = 1'b1;
      state_nxt = e_rxdv ? DROP : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (e_rxdv) begin
            if (!rxdv_p1 && e_rxd == PREAMBLE_BYTE) begin
              state_nxt = PREAMBLE;
              cnt_nxt   = 16'd1;
            end else begin
              state_nxt = DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!e_rxdv) begin
            state_nxt = IDLE;
          end else if (e_rxd == PREAMBLE_BYTE) begin
            cnt_nxt = sat_inc(cnt);
          end else if (e_rxd == SFD_BYTE && cnt >= MIN_PREAMBLE) begin
            state_nxt = ETH_HDR;
            cnt_nxt   = '0;
          end else begin
            state_nxt = DROP;
          end
        end
        ETH_HDR: begin
          cnt_nxt = sat_inc(cnt);
          // At byte 6 the shift register holds the full destination MAC.
          if (cnt == 16'd6 && hdr_p1 != LOCAL_MAC && hdr_p1 != BCAST_MAC) begin
            state_nxt = DROP;
          end else if (cnt == ETH_HDR_LEN - 16'd1) begin
            if ({hdr_p1[7:0], e_rxd} != ETHERTYPE_IPV4) begin
              state_nxt = DROP;
            end else begin
              state_nxt = IP_HDR;
              cnt_nxt   = '0;
            end
          end
        end
        IP_HDR: begin
          cnt_nxt = sat_inc(cnt);
          if (cnt == 16'd0 && e_rxd != IP_VER_IHL) begin
            state_nxt = DROP;
          end else if (cnt == 16'd3) begin
            total_len_nxt = {hdr_p1[7:0], e_rxd};
          end else if (cnt == 16'd9 && e_rxd != IP_PROTO_UDP) begin
            state_nxt = DROP;
          end else if (cnt == IP_HDR_LEN - 16'd1) begin
            if ({hdr_p1[23:0], e_rxd} != LOCAL_IP) begin
              state_nxt = DROP;
            end else begin
              state_nxt = UDP_HDR;
              cnt_nxt   = '0;
            end
          end
        end
        UDP_HDR: begin
          cnt_nxt = sat_inc(cnt);
          if (cnt == 16'd3 && {hdr_p1[7:0], e_rxd} != LOCAL_PORT) begin
            state_nxt = DROP;
          end else if (cnt == UDP_HDR_LEN - 16'd1) begin
            // UDP length sits two bytes behind the checksum byte being sampled.
            if (hdr_p1[23:8] < UDP_HDR_LEN) begin
              state_nxt = DROP;
            end else begin
              data_len_nxt = hdr_p1[23:8] - UDP_HDR_LEN;
              cnt_nxt      = '0;
              if (hdr_p1[23:8] == UDP_HDR_LEN) begin
                done_nxt  = 1'b1;
                state_nxt = DROP;
              end else begin
                state_nxt = PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          pk_vld  = 1'b1;
          pk_last = ({1'b0, cnt} + 17'd1 == {1'b0, rx_data_length});
          cnt_nxt = sat_inc(cnt);
          if (pk_last) begin
            done_nxt  = 1'b1;
            state_nxt = DROP;
          end
        end
        DROP: begin
          if (!e_rxdv) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // p0 -> p1: control state and status outputs
  always_ff @(posedge e_rxc) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      rx_total_length <= '0;
      rx_data_length  <= '0;
      data_received   <= 1'b0;
      rx_frame_err    <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      rx_total_length <= total_len_nxt;
      rx_data_length  <= data_len_nxt;
      data_received   <= done_nxt;
      rx_frame_err    <= err_nxt;
    end
  end

  always_ff @(posedge e_rxc) begin
    rxdv_p1 <= e_rxdv;
    if (e_rxdv) hdr_p1 <= {hdr_p1[39:0], e_rxd};
  end

  udp_rx_word_pack u_pack (
    .clk       (e_rxc),
    .reset     (reset),
    .clr       (pk_clr),
    .byte_vld  (pk_vld),
    .byte_in   (e_rxd),
    .byte_last (pk_last),
    .word      (rx_data),
    .word_vld  (rx_data_valid),
    .word_keep (rx_data_keep),
    .word_last (rx_data_last)
  );

endmodule
